// File: rtl/dmem_access_unit_pkg.sv
// Shared types and helpers for the MEM-stage data memory access unit.
// Holds the LSU state encoding, the byte-enable base masks and the load/store width decode.
package dmem_access_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Undefined encodings fall through to word width, as the decoder does.
    function automatic logic [3:0] base_mask(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: base_mask = MASK_B;
            F3_H, F3_HU: base_mask = MASK_H;
            default:     base_mask = MASK_W;
        endcase
    endfunction

    function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] offset);
        case (f3)
            F3_B, F3_BU: is_aligned = 1'b1;
            F3_H, F3_HU: is_aligned = ~offset[0];
            default:     is_aligned = (offset == 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/dmem_access_unit_if.sv
// L1 data cache port: request lines driven by the access unit, completion from the cache.
interface dmem_access_unit_if;

    logic        dmem_read;
    logic        dmem_write;
    logic [31:0] dmem_address;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_mbe;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;

    modport master (
        output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_mbe,
        input  dmem_rdata, dmem_resp
    );

    modport slave (
        input  dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_mbe,
        output dmem_rdata, dmem_resp
    );

endinterface

// File: rtl/dmem_access_unit_load_align.sv
// Load extraction: shifts the addressed bytes down to bit 0 and sign/zero-extends by funct3.
module load_align
    import dmem_access_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [31:0] shifted;

    assign shifted = rdata >> {offset, 3'b000};

    always_comb begin
        case (funct3)
            F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   result = {24'h000000, shifted[7:0]};
            F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   result = {16'h0000, shifted[15:0]};
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage load/store unit: aligns stores, issues one cache request per instruction,
// stalls the pipeline until the cache responds, and returns extended load data.
module dmem_access_unit
    import dmem_access_unit_pkg::*;
#(
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    input  logic                      mem_read,
    input  logic                      mem_write,
    input  logic [2:0]                funct3,
    input  logic [31:0]               addr,
    input  logic [31:0]               rs2_data,
    output logic                      stall,
    output logic [31:0]               load_data,
    output logic                      load_valid,
    output logic                      misaligned,
    dmem_access_unit_if.master        dmem
);

    lsu_state_t  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  mbe_q, mbe_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  offset_q, offset_d;
    logic        write_q, write_d;
    logic [31:0] load_data_q, load_data_d;
    logic        load_valid_q, load_valid_d;
    logic        misaligned_q, misaligned_d;

    logic        new_req;
    logic        aligned;
    logic [3:0]  mbe_shifted;
    logic [31:0] load_result;

    assign new_req     = req_valid & (mem_read | mem_write);
    assign aligned     = ALIGN_CHECK ? is_aligned(funct3, addr[1:0]) : 1'b1;
    assign mbe_shifted = base_mask(funct3) << addr[1:0];

    load_align u_load_align (
        .rdata  (dmem.dmem_rdata),
        .offset (offset_q),
        .funct3 (funct3_q),
        .result (load_result)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        mbe_d        = mbe_q;
        funct3_d     = funct3_q;
        offset_d     = offset_q;
        write_d      = write_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        misaligned_d = 1'b0;
        stall        = 1'b0;

        case (state_q)
            IDLE: begin
                if (new_req) begin
                    if (aligned) begin
                        addr_d   = {addr[31:2], 2'b00};
                        wdata_d  = rs2_data << {addr[1:0], 3'b000};
                        mbe_d    = mbe_shifted;
                        funct3_d = funct3;
                        offset_d = addr[1:0];
                        write_d  = mem_write;
                        stall    = 1'b1;
                        state_d  = BUSY;
                    end else begin
                        misaligned_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (dmem.dmem_resp) begin
                    // A simultaneous read+write is treated as a store, so it never produces load data.
                    if (!write_q) begin
                        load_data_d  = load_result;
                        load_valid_d = 1'b1;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            mbe_q        <= '0;
            funct3_q     <= '0;
            offset_q     <= '0;
            write_q      <= 1'b0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            mbe_q        <= mbe_d;
            funct3_q     <= funct3_d;
            offset_q     <= offset_d;
            write_q      <= write_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign dmem.dmem_read    = (state_q == BUSY) & ~write_q;
    assign dmem.dmem_write   = (state_q == BUSY) & write_q;
    assign dmem.dmem_address = addr_q;
    assign dmem.dmem_wdata   = wdata_q;
    assign dmem.dmem_mbe     = mbe_q;

    assign load_data  = load_data_q;
    assign load_valid = load_valid_q;
    assign misaligned = misaligned_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: directed scenarios plus randomized accesses
// checked against an arithmetic reference model of the load/store rules.
module tb_dmem_access_unit;
    import dmem_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] rs2_data;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        misaligned;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    dmem_access_unit_if dmem_bus ();

    dmem_access_unit #(.ALIGN_CHECK(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .addr       (addr),
        .rs2_data   (rs2_data),
        .stall      (stall),
        .load_data  (load_data),
        .load_valid (load_valid),
        .misaligned (misaligned),
        .dmem       (dmem_bus)
    );

    // Reference model: access width in bytes, derived from the funct3 size field.
    function automatic int acc_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit model_aligned(input logic [2:0] f3, input logic [31:0] a);
        return (int'(a[1:0]) % acc_size(f3)) == 0;
    endfunction

    function automatic logic [3:0] model_mbe(input logic [2:0] f3, input logic [31:0] a);
        longint m;
        m = ((longint'(1) << acc_size(f3)) - 1) << int'(a[1:0]);
        return 4'(m & 15);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] d, input logic [31:0] a);
        longint w;
        w = longint'(d) << (8 * int'(a[1:0]));
        return 32'(w);
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rd);
        longint v;
        int     bits;
        v    = longint'(rd) >> (8 * int'(a[1:0]));
        bits = 8 * acc_size(f3);
        if (bits < 32) begin
            v = v % (longint'(1) << bits);
            if (!f3[2] && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
        end
        return 32'(v);
    endfunction

    // Drives one instruction, scrambles the inputs while it is stalled, answers the cache
    // request after 'delay' busy cycles and gathers what the DUT did.
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] d, input logic [31:0] rdat,
                             input int delay, input int trail,
                             output int n_stall, output int n_rd, output int n_wr,
                             output int n_lv, output int n_mis, output int n_chg,
                             output logic [31:0] o_addr, output logic [31:0] o_wdata,
                             output logic [3:0] o_mbe, output logic [31:0] o_ld,
                             output bit timeout);
        int  busy_cnt;
        bit  seen_req;
        bit  done;
        logic prev_rd, prev_wr;
        n_stall = 0; n_rd = 0; n_wr = 0; n_lv = 0; n_mis = 0; n_chg = 0;
        o_addr = '0; o_wdata = '0; o_mbe = '0; o_ld = '0;
        busy_cnt = 0; seen_req = 0; done = 0; timeout = 0;
        prev_rd = 1'b0; prev_wr = 1'b0;
        for (int cyc = 0; cyc < 30 + trail && !(done && cyc > 0 && trail == 0); cyc++) begin
            @(posedge clk);
            #1;
            dmem_bus.dmem_resp  = 1'b0;
            dmem_bus.dmem_rdata = $urandom;
            if (cyc == 0) begin
                req_valid = 1'b1; mem_read = rd; mem_write = wr;
                funct3 = f3; addr = a; rs2_data = d;
            end else if (!done) begin
                mem_read = 1'($urandom); mem_write = 1'($urandom);
                funct3 = 3'($urandom); addr = $urandom; rs2_data = $urandom;
            end else begin
                req_valid = 1'b0;
                trail--;
            end
            @(negedge clk);
            if (stall) n_stall++;
            if (misaligned) n_mis++;
            if (dmem_bus.dmem_read && !prev_rd) n_rd++;
            if (dmem_bus.dmem_write && !prev_wr) n_wr++;
            prev_rd = dmem_bus.dmem_read;
            prev_wr = dmem_bus.dmem_write;
            if (load_valid) begin
                n_lv++;
                o_ld = load_data;
            end
            if (dmem_bus.dmem_read || dmem_bus.dmem_write) begin
                if (!seen_req) begin
                    seen_req = 1;
                    o_addr = dmem_bus.dmem_address;
                    o_wdata = dmem_bus.dmem_wdata;
                    o_mbe = dmem_bus.dmem_mbe;
                end else if (o_addr !== dmem_bus.dmem_address || o_wdata !== dmem_bus.dmem_wdata ||
                             o_mbe !== dmem_bus.dmem_mbe) begin
                    n_chg++;
                end
                busy_cnt++;
                if (busy_cnt == delay) begin
                    dmem_bus.dmem_resp  = 1'b1;
                    dmem_bus.dmem_rdata = rdat;
                end
            end
            if (!done && !stall) done = 1;
            if (done && trail <= 0 && cyc > 0) break;
        end
        if (!done) timeout = 1;
        req_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        funct3 = '0; addr = '0; rs2_data = '0;
        dmem_bus.dmem_resp = 1'b0; dmem_bus.dmem_rdata = '0;
        @(negedge clk);
        tests_run++;
        if ({stall, load_valid, misaligned, dmem_bus.dmem_read, dmem_bus.dmem_write} !== 5'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_ctrl: got %b expected 00000",
                     {stall, load_valid, misaligned, dmem_bus.dmem_read, dmem_bus.dmem_write});
        end
        tests_run++;
        if ({dmem_bus.dmem_address, dmem_bus.dmem_wdata, dmem_bus.dmem_mbe, load_data} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_data: addr=%h wdata=%h mbe=%b ld=%h expected all zero",
                     dmem_bus.dmem_address, dmem_bus.dmem_wdata, dmem_bus.dmem_mbe, load_data);
        end
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_store_word();
        int ns, nr, nw, nl, nm, nc; logic [31:0] oa, owd, old; logic [3:0] om; bit to;
        do_access(1'b0, 1'b1, F3_W, 32'h100, 32'hDEADBEEF, 32'h0, 3, 0,
                  ns, nr, nw, nl, nm, nc, oa, owd, om, old, to);
        tests_run++;
        if (to || ns !== 4 || nw !== 1 || nr !== 0 || nl !== 0) begin
            tests_failed++;
            $display("[TB] FAIL sw_timing: stall=%0d wr=%0d rd=%0d lv=%0d to=%0d expected 4 1 0 0 0",
                     ns, nw, nr, nl, to);
        end
        tests_run++;
        if (oa !== 32'h100 || owd !== 32'hDEADBEEF || om !== 4'b1111) begin
            tests_failed++;
            $display("[TB] FAIL sw_fields: addr=%h wdata=%h mbe=%b expected 00000100 deadbeef 1111",
                     oa, owd, om);
        end
    endtask

    task automatic test_store_byte();
        int ns, nr, nw, nl, nm, nc; logic [31:0] oa, owd, old; logic [3:0] om; bit to;
        do_access(1'b0, 1'b1, F3_B, 32'h203, 32'h000000A5, 32'h0, 1, 0,
                  ns, nr, nw, nl, nm, nc, oa, owd, om, old, to);
        tests_run++;
        if (to || oa !== 32'h200 || owd !== 32'hA5000000 || om !== 4'b1000 || nc !== 0) begin
            tests_failed++;
            $display("[TB] FAIL sb_fields: addr=%h wdata=%h mbe=%b chg=%0d expected 00000200 a5000000 1000 0",
                     oa, owd, om, nc);
        end
    endtask

    task automatic test_load_extend();
        logic [2:0]  f3s [3] = '{F3_B, F3_BU, F3_H};
        logic [31:0] exps[3] = '{32'hFFFFFF80, 32'h00000080, 32'h00001280};
        int ns, nr, nw, nl, nm, nc; logic [31:0] oa, owd, old; logic [3:0] om; bit to;
        for (int i = 0; i < 3; i++) begin
            do_access(1'b1, 1'b0, f3s[i], 32'h102, 32'h0, 32'h1280FF00, 2, 0,
                      ns, nr, nw, nl, nm, nc, oa, owd, om, old, to);
            tests_run++;
            if (to || nl !== 1 || nr !== 1 || old !== exps[i] || oa !== 32'h100) begin
                tests_failed++;
                $display("[TB] FAIL load_ext f3=%b: ld=%h lv=%0d rd=%0d addr=%h expected %h 1 1 00000100",
                         f3s[i], old, nl, nr, oa, exps[i]);
            end
        end
    endtask

    task automatic test_misaligned();
        int ns, nr, nw, nl, nm, nc; logic [31:0] oa, owd, old; logic [3:0] om; bit to;
        do_access(1'b1, 1'b0, F3_W, 32'h101, 32'h0, 32'h0, 1, 2,
                  ns, nr, nw, nl, nm, nc, oa, owd, om, old, to);
        tests_run++;
        if (to || nm !== 1 || ns !== 0 || nr !== 0 || nl !== 0) begin
            tests_failed++;
            $display("[TB] FAIL lw_misaligned: mis=%0d stall=%0d rd=%0d lv=%0d expected 1 0 0 0",
                     nm, ns, nr, nl);
        end
    endtask

    task automatic test_back_to_back();
        int ns, nr, nw, nl, nm, nc; logic [31:0] oa, owd, old; logic [3:0] om; bit to;
        do_access(1'b1, 1'b0, F3_W, 32'h40, 32'h0, 32'h13579BDF, 2, 0,
                  ns, nr, nw, nl, nm, nc, oa, owd, om, old, to);
        tests_run++;
        if (to || nr !== 1 || ns !== 3 || old !== 32'h13579BDF) begin
            tests_failed++;
            $display("[TB] FAIL b2b_first: rd=%0d stall=%0d ld=%h expected 1 3 13579bdf", nr, ns, old);
        end
        do_access(1'b1, 1'b0, F3_HU, 32'h46, 32'h0, 32'hF00DCAFE, 2, 1,
                  ns, nr, nw, nl, nm, nc, oa, owd, om, old, to);
        tests_run++;
        if (to || nr !== 1 || ns !== 3 || nl !== 1 || old !== 32'h0000F00D || oa !== 32'h44) begin
            tests_failed++;
            $display("[TB] FAIL b2b_second: rd=%0d stall=%0d lv=%0d ld=%h addr=%h expected 1 3 1 0000f00d 00000044",
                     nr, ns, nl, old, oa);
        end
    endtask

    task automatic test_reset_mid();
        int ns, nr, nw, nl, nm, nc; logic [31:0] oa, owd, old; logic [3:0] om; bit to;
        @(posedge clk);
        #1 req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = F3_W; addr = 32'h80;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (dmem_bus.dmem_read !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL rst_mid_busy: dmem_read=%b expected 1", dmem_bus.dmem_read);
        end
        #2 rst = 1'b0;
        #1;
        tests_run++;
        if (dmem_bus.dmem_read !== 1'b0 || stall !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rst_mid_drop: dmem_read=%b stall=%b expected 0 0",
                     dmem_bus.dmem_read, stall);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dmem_bus.dmem_resp = 1'b1; dmem_bus.dmem_rdata = 32'hBAD0BAD0;
        @(posedge clk);
        #1 dmem_bus.dmem_resp = 1'b0;
        @(negedge clk);
        tests_run++;
        if (load_valid !== 1'b0 || stall !== 1'b0 || dmem_bus.dmem_read !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rst_mid_late_resp: lv=%b stall=%b rd=%b expected 0 0 0",
                     load_valid, stall, dmem_bus.dmem_read);
        end
        do_access(1'b1, 1'b0, F3_W, 32'h84, 32'h0, 32'h0BADF00D, 1, 0,
                  ns, nr, nw, nl, nm, nc, oa, owd, om, old, to);
        tests_run++;
        if (to || nr !== 1 || ns !== 2 || old !== 32'h0BADF00D) begin
            tests_failed++;
            $display("[TB] FAIL rst_mid_recover: rd=%0d stall=%0d ld=%h expected 1 2 0badf00d", nr, ns, old);
        end
    endtask

    task automatic test_random();
        int ns, nr, nw, nl, nm, nc; logic [31:0] oa, owd, old; logic [3:0] om; bit to;
        for (int i = 0; i < 40; i++) begin
            int          op;
            logic        rd, wr;
            logic [2:0]  f3;
            logic [31:0] a, d, rdat;
            int          dly;
            bit          ok;
            int          e_rd, e_wr, e_lv;
            op   = $urandom_range(0, 2);
            rd   = (op != 1);
            wr   = (op != 0);
            f3   = 3'($urandom);
            a    = $urandom;
            d    = $urandom;
            rdat = $urandom;
            dly  = $urandom_range(1, 4);
            do_access(rd, wr, f3, a, d, rdat, dly, 1,
                      ns, nr, nw, nl, nm, nc, oa, owd, om, old, to);
            ok   = model_aligned(f3, a);
            e_rd = (ok && !wr) ? 1 : 0;
            e_wr = (ok && wr) ? 1 : 0;
            e_lv = e_rd;
            tests_run++;
            if (to || ns !== (ok ? dly + 1 : 0) || nm !== (ok ? 0 : 1) || nr !== e_rd ||
                nw !== e_wr || nl !== e_lv || nc !== 0) begin
                tests_failed++;
                $display("[TB] FAIL rand_ctrl[%0d] f3=%b a=%h rd=%b wr=%b: stall=%0d mis=%0d nrd=%0d nwr=%0d lv=%0d chg=%0d to=%0d expected stall=%0d mis=%0d nrd=%0d nwr=%0d lv=%0d chg=0",
                         i, f3, a, rd, wr, ns, nm, nr, nw, nl, nc, to,
                         ok ? dly + 1 : 0, ok ? 0 : 1, e_rd, e_wr, e_lv);
            end
            if (ok) begin
                tests_run++;
                if (oa !== {a[31:2], 2'b00} || om !== model_mbe(f3, a) ||
                    (wr && owd !== model_wdata(d, a))) begin
                    tests_failed++;
                    $display("[TB] FAIL rand_req[%0d]: addr=%h mbe=%b wdata=%h expected %h %b %h",
                             i, oa, om, owd, {a[31:2], 2'b00}, model_mbe(f3, a), model_wdata(d, a));
                end
            end
            if (e_lv == 1) begin
                tests_run++;
                if (old !== model_load(f3, a, rdat)) begin
                    tests_failed++;
                    $display("[TB] FAIL rand_load[%0d] f3=%b off=%0d rdata=%h: ld=%h expected %h",
                             i, f3, a[1:0], rdat, old, model_load(f3, a, rdat));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_store_byte();
        test_load_extend();
        test_misaligned();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
